// File: rtl/iic_cmd_seq.sv
// IIC transaction sequencer: turns read/write requests into START/addr/data/STOP commands.
// Optional IIC_TIMEOUT_EN adds a TO_CYCLES watchdog on command and response waits.
module iic_cmd_seq #(
   parameter int TO_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_addr,
   input  logic [3:0] req_len,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       nack_err,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [1:0] cmd_op,
   output logic [7:0] cmd_data,
   output logic       cmd_last,
   input  logic       rsp_valid,
   input  logic       rsp_ack,
   input  logic [7:0] rsp_data
);

   typedef enum logic [2:0] {
      IDLE, START, ADDR, WDATA, RDATA, STOP, FIN
   } state_t;

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_STOP  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   state_t     state;
   logic       rw_q;
   logic [6:0] addr_q;
   logic [3:0] cnt;
   logic       nack;
   logic       pend;
   logic       hs;
   logic       rsp_hit;
   logic       waiting;
   logic       to_hit;

   assign hs      = cmd_valid && cmd_ready;
   assign rsp_hit = pend && rsp_valid;
   assign waiting = cmd_valid || pend;

`ifdef IIC_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   assign to_hit = waiting && !hs && !rsp_hit &&
                   (to_cnt == TW'(TO_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset || !waiting || hs || rsp_hit || to_hit)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         cnt       <= '0;
         nack      <= 1'b0;
         pend      <= 1'b0;
         req_ready <= 1'b0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         nack_err  <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_op    <= '0;
         cmd_data  <= '0;
         cmd_last  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         nack_err <= 1'b0;
         if (hs) begin
            cmd_valid <= 1'b0;
            pend      <= 1'b1;
         end
         if (to_hit) begin
            // watchdog abandons the bus without a STOP
            state     <= FIN;
            cmd_valid <= 1'b0;
            pend      <= 1'b0;
            wr_ready  <= 1'b0;
            done      <= 1'b1;
            nack_err  <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  req_ready <= 1'b1;
                  if (req_valid && req_ready) begin
                     req_ready <= 1'b0;
                     rw_q      <= req_rw;
                     addr_q    <= req_addr;
                     cnt       <= req_len;
                     nack      <= 1'b0;
                     state     <= START;
                     cmd_valid <= 1'b1;
                     cmd_op    <= OP_START;
                     cmd_data  <= '0;
                     cmd_last  <= 1'b0;
                  end
               end
               START: begin
                  if (rsp_hit) begin
                     pend      <= 1'b0;
                     state     <= ADDR;
                     cmd_valid <= 1'b1;
                     cmd_op    <= OP_WRITE;
                     cmd_data  <= {addr_q, rw_q};
                     cmd_last  <= 1'b0;
                  end
               end
               ADDR: begin
                  if (rsp_hit) begin
                     pend <= 1'b0;
                     if (!rsp_ack || cnt == 4'd0) begin
                        nack      <= !rsp_ack;
                        state     <= STOP;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_STOP;
                        cmd_data  <= '0;
                        cmd_last  <= 1'b0;
                     end else if (rw_q) begin
                        state     <= RDATA;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_READ;
                        cmd_data  <= '0;
                        cmd_last  <= (cnt == 4'd1);
                     end else begin
                        state    <= WDATA;
                        wr_ready <= 1'b1;
                     end
                  end
               end
               WDATA: begin
                  if (wr_ready && wr_valid) begin
                     wr_ready  <= 1'b0;
                     cmd_valid <= 1'b1;
                     cmd_op    <= OP_WRITE;
                     cmd_data  <= wr_data;
                     cmd_last  <= 1'b0;
                  end
                  if (rsp_hit) begin
                     pend <= 1'b0;
                     cnt  <= cnt - 1'b1;
                     if (!rsp_ack || cnt == 4'd1) begin
                        nack      <= !rsp_ack;
                        state     <= STOP;
                        cmd_valid <= 1'b1;
                        cmd_op    <= OP_STOP;
                        cmd_data  <= '0;
                     end else begin
                        wr_ready <= 1'b1;
                     end
                  end
               end
               RDATA: begin
                  if (rsp_hit) begin
                     pend      <= 1'b0;
                     rd_valid  <= 1'b1;
                     rd_data   <= rsp_data;
                     cnt       <= cnt - 1'b1;
                     cmd_valid <= 1'b1;
                     cmd_data  <= '0;
                     if (cnt == 4'd1) begin
                        state    <= STOP;
                        cmd_op   <= OP_STOP;
                        cmd_last <= 1'b0;
                     end else begin
                        cmd_op   <= OP_READ;
                        cmd_last <= (cnt == 4'd2);
                     end
                  end
               end
               STOP: begin
                  if (rsp_hit) begin
                     pend     <= 1'b0;
                     state    <= FIN;
                     done     <= 1'b1;
                     nack_err <= nack;
                  end
               end
               FIN: begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iic_cmd_seq.sv
// Directed bench for iic_cmd_seq with a simple bit-engine responder.
// Define IIC_TIMEOUT_EN to also exercise the watchdog.
module tb_iic_cmd_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_rw;
   logic [6:0] req_addr;
   logic [3:0] req_len;
   logic [7:0] wr_data;
   logic       wr_valid, wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid, done, nack_err;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cmd_last;
   logic       rsp_valid, rsp_ack;
   logic [7:0] rsp_data;

   iic_cmd_seq #(.TO_CYCLES(255)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rw(req_rw), .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .nack_err(nack_err),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_last(cmd_last),
      .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   int hold_after = 0;
   bit no_rsp = 0;
   bit wr_seen = 0;
   logic last_nack = 1'b0;
   logic [10:0] log_q[$];
   logic [7:0]  rd_log[$];
   logic [7:0]  wr_q[$];
   logic [7:0]  rd_q[$];
   logic        ack_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic chk_cmd(input int idx, input logic [1:0] op,
                          input logic [7:0] data, input logic last);
      logic [10:0] e;
      if (idx >= log_q.size()) begin
         chk($sformatf("cmd%0d_present", idx), log_q.size(), idx + 1);
         return;
      end
      e = log_q[idx];
      chk($sformatf("cmd%0d_op", idx), e[10:9], op);
      if (op >= 2'd2) chk($sformatf("cmd%0d_data", idx), e[8:1], data);
      if (op == 2'd3) chk($sformatf("cmd%0d_last", idx), e[0], last);
   endtask

   // bit-engine model: accept after one cycle, respond two cycles later
   initial begin
      logic [1:0] op;
      cmd_ready = 0; rsp_valid = 0; rsp_ack = 0; rsp_data = 0;
      forever begin
         @(negedge clk);
         if (cmd_valid && !(hold_after != 0 && log_q.size() >= hold_after)) begin
            cmd_ready = 1;
            log_q.push_back({cmd_op, cmd_data, cmd_last});
            hs_cyc = cyc + 1;
            op = cmd_op;
            @(negedge clk);
            cmd_ready = 0;
            if (!no_rsp) begin
               @(negedge clk);
               rsp_valid = 1;
               rsp_ack = 1'b1;
               rsp_data = 8'h00;
               if (op == 2'd2 && ack_q.size() > 0) rsp_ack = ack_q.pop_front();
               if (op == 2'd3 && rd_q.size() > 0) rsp_data = rd_q.pop_front();
               @(negedge clk);
               rsp_valid = 0;
            end
         end
      end
   end

   initial begin
      wr_valid = 0; wr_data = 0;
      forever begin
         @(negedge clk);
         if (wr_q.size() > 0) begin
            wr_valid = 1;
            wr_data = wr_q[0];
            if (wr_ready) void'(wr_q.pop_front());
         end else begin
            wr_valid = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rd_valid) rd_log.push_back(rd_data);
         if (wr_ready) wr_seen = 1;
         if (done) begin
            done_cnt++;
            last_nack = nack_err;
            done_cyc = cyc;
         end
      end
   end

   task automatic start_txn(input logic rw, input logic [6:0] a,
                            input logic [3:0] l);
      int n;
      @(negedge clk);
      log_q.delete(); rd_log.delete();
      wr_seen = 0; done_cnt = 0;
      req_valid = 1; req_rw = rw; req_addr = a; req_len = l;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      req_valid = 0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk({tag, "_done"}, done_cnt, 1);
   endtask

   initial begin
      reset = 0; req_valid = 0; req_rw = 0; req_addr = 0; req_len = 0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_cmd", {cmd_valid, cmd_op, cmd_data, cmd_last}, 0);
      chk("rst_rd", {rd_valid, rd_data}, 0);
      chk("rst_done", {done, nack_err}, 0);
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      chk("post_rst_req_ready", req_ready, 1);

      wr_q = '{8'hA5, 8'h3C};
      start_txn(1'b0, 7'h50, 4'd2);
      wait_done("wr");
      chk("wr_ncmd", log_q.size(), 5);
      chk_cmd(0, 2'd0, 8'h00, 1'b0);
      chk_cmd(1, 2'd2, 8'hA0, 1'b0);
      chk_cmd(2, 2'd2, 8'hA5, 1'b0);
      chk_cmd(3, 2'd2, 8'h3C, 1'b0);
      chk_cmd(4, 2'd1, 8'h00, 1'b0);
      chk("wr_nack", last_nack, 0);

      rd_q = '{8'h11, 8'h22, 8'h33};
      start_txn(1'b1, 7'h50, 4'd3);
      wait_done("rd");
      chk("rd_ncmd", log_q.size(), 6);
      chk_cmd(1, 2'd2, 8'hA1, 1'b0);
      chk_cmd(2, 2'd3, 8'h00, 1'b0);
      chk_cmd(3, 2'd3, 8'h00, 1'b0);
      chk_cmd(4, 2'd3, 8'h00, 1'b1);
      chk_cmd(5, 2'd1, 8'h00, 1'b0);
      chk("rd_nbytes", rd_log.size(), 3);
      if (rd_log.size() == 3) begin
         chk("rd_b0", rd_log[0], 8'h11);
         chk("rd_b1", rd_log[1], 8'h22);
         chk("rd_b2", rd_log[2], 8'h33);
      end
      chk("rd_nack", last_nack, 0);

      wr_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      ack_q = '{1'b0};
      start_txn(1'b0, 7'h50, 4'd4);
      wait_done("nak");
      chk("nak_ncmd", log_q.size(), 3);
      chk_cmd(0, 2'd0, 8'h00, 1'b0);
      chk_cmd(1, 2'd2, 8'hA0, 1'b0);
      chk_cmd(2, 2'd1, 8'h00, 1'b0);
      chk("nak_wr_ready", wr_seen, 0);
      chk("nak_nack", last_nack, 1);
      wr_q.delete();

      start_txn(1'b0, 7'h3F, 4'd0);
      wait_done("probe");
      chk("probe_ncmd", log_q.size(), 3);
      chk_cmd(1, 2'd2, 8'h7E, 1'b0);
      chk_cmd(2, 2'd1, 8'h00, 1'b0);
      chk("probe_nack", last_nack, 0);

      begin
         int n = 0;
         wr_q = '{8'h5A, 8'hC3};
         hold_after = 3;
         start_txn(1'b0, 7'h50, 4'd2);
         while (!(cmd_valid && log_q.size() >= 3) && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("abort_stalled", cmd_valid, 1);
         reset = 0;
         @(posedge clk); #1;
         chk("abort_cmd_valid", cmd_valid, 0);
         chk("abort_req_ready", req_ready, 0);
         repeat (3) @(negedge clk);
         hold_after = 0;
         wr_q.delete();
         reset = 1;
         @(posedge clk); #1;
         chk("abort_req_ready_up", req_ready, 1);
         repeat (10) @(negedge clk);
         chk("abort_no_done", done_cnt, 0);
         chk("abort_no_stop", log_q.size(), 3);
      end

`ifdef IIC_TIMEOUT_EN
      no_rsp = 1;
      start_txn(1'b0, 7'h50, 4'd1);
      wait_done("to");
      chk("to_nack", last_nack, 1);
      chk("to_latency", done_cyc - hs_cyc, 255);
      chk("to_ncmd", log_q.size(), 1);
      no_rsp = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
